reg_dump_reader: RTL and testbench



---
 rtl/reg_dump_pkg.sv | 21 ++
 rtl/reg_dump_csum.sv | 30 +++
 rtl/reg_dump_reader.sv | 141 ++++++++++++++
 tb/tb_reg_dump_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register-file dump reader.
package reg_dump_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_NUM_REGS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_CSUM,
    S_FIN
  } state_t;

  // The checksum word is tagged one past the last register number.
  function automatic int csum_index(input int num_regs);
    return num_regs;
  endfunction

endpackage

// File: rtl/reg_dump_csum.sv
// XOR accumulator over dumped words; clear has priority over enable.
module reg_dump_csum
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q ^ data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks register addresses FIRST_REG..NUM_REGS-1 and streams each word on valid/ready.
// REG_DUMP_CHECKSUM_EN appends an XOR checksum word tagged with index NUM_REGS.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int FIRST_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   out_index,
  output logic              out_last
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W:0]   out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              last_idx;

  assign last_idx = (idx_q == ADDR_W'(NUM_REGS - 1));

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
  logic              acc_clr, acc_en;
  logic [DATA_W-1:0] acc;

  reg_dump_csum #(.DATA_W(DATA_W)) u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .data_i (rd_data),
    .acc_o  (acc)
  );
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = ADDR_W'(FIRST_REG);
          state_d = S_READ;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_clr = 1'b1;
`endif
        end
      end
      S_READ: begin
        out_data_d  = rd_data;
        out_index_d = {1'b0, idx_q};
        out_valid_d = 1'b1;
        out_last_d  = last_idx && !CSUM_ON;
        state_d     = S_SEND;
`ifdef REG_DUMP_CHECKSUM_EN
        acc_en      = 1'b1;
`endif
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_idx) begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Accumulator already holds the last word, folded in at its READ edge.
            out_data_d  = acc;
            out_index_d = (ADDR_W+1)'(csum_index(NUM_REGS));
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_CSUM;
`else
            state_d     = S_FIN;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_CSUM: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Busy covers the FIN cycle so it drops together with the done pulse.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign rd_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader with a behavioural 8x32 register file.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct packed {
    logic        last;
    logic [3:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst_n, start, busy, done, out_valid, out_ready, out_last;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data, out_data;
  logic [3:0]  out_index;

  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rf [8];
  logic [31:0] shadow [8];

  exp_t sb [$];
  int   n_cmp, n_err;
  int   cyc, busy_cnt, done_cnt, done_cyc, last_hs_cyc, stall_cnt;
  logic prev_stall;
  exp_t prev_word;

  reg_dump_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  assign rd_data = rf[rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold during stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", 64'({out_last, out_index, out_data}), 64'(prev_word));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: got idx %0d data 0x%0h, expected no word", out_index, out_data);
        end else begin
          check("word", 64'({out_last, out_index, out_data}), 64'(sb.pop_front()));
        end
        last_hs_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_index, out_data};
      if (prev_stall) stall_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_write(input logic [2:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    shadow[a] = d;
  endtask

  task automatic push_dump();
    exp_t        e;
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < 8; i++) begin
      e.last = (i == 7) && !CSUM;
      e.idx  = 4'(i);
      e.data = shadow[i];
      sb.push_back(e);
      x = x ^ shadow[i];
    end
    if (CSUM) begin
      e.last = 1'b1;
      e.idx  = 4'd8;
      e.data = x;
      sb.push_back(e);
    end
  endtask

  task automatic clear_counts();
    busy_cnt  = 0;
    done_cnt  = 0;
    stall_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (done) found = 1'b1;
      else tick();
    end
    check(name, 64'(found), 64'd1);
    tick();
    tick();
  endtask

  task automatic wait_word(input string name, input logic [3:0] idx);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (out_valid && out_index == idx) found = 1'b1;
    end
    check(name, 64'(found), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_valid"},     64'(out_valid), 64'd0);
    check({tag, "_last"},      64'(out_last),  64'd0);
    check({tag, "_data"},      64'(out_data),  64'd0);
    check({tag, "_index"},     64'(out_index), 64'd0);
    check({tag, "_rd_addr"},   64'(rd_addr),   64'd0);
  endtask

  int exp_busy;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    clear_counts();
    prev_stall = 1'b0;
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    exp_busy = 17 + (CSUM ? 1 : 0);
    #3 rst_n = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) rf_write(3'(i), 32'h10 * i + 32'h1);

    // Basic dump with ready tied high
    clear_counts();
    push_dump();
    pulse_start();
    check("t1_valid_after_1_edge", 64'(out_valid), 64'd0);
    check("t1_rd_addr_first", 64'(rd_addr), 64'd0);
    tick();
    check("t1_valid_after_2_edges", 64'(out_valid), 64'd1);
    wait_done("t1_done_seen");
    check("t1_busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    check("t1_done_count", 64'(done_cnt), 64'd1);
    check("t1_done_after_last_hs", 64'(done_cyc), 64'(last_hs_cyc + 1));
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure on word 3 for five cycles
    clear_counts();
    push_dump();
    pulse_start();
    wait_word("t2_word3_seen", 4'd3);
    out_ready = 1'b0;
    repeat (5) tick();
    check("t2_held_data", 64'(out_data), 64'h31);
    out_ready = 1'b1;
    wait_done("t2_done_seen");
    check("t2_stall_cycles", 64'(stall_cnt), 64'd5);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Start held into the next cycle and pulsed again mid-dump
    clear_counts();
    push_dump();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    repeat (4) tick();
    pulse_start();
    wait_done("t3_done_seen");
    repeat (5) tick();
    check("t3_done_count", 64'(done_cnt), 64'd1);
    check("t3_idle_valid", 64'(out_valid), 64'd0);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset while word 4 is stalled in SEND
    clear_counts();
    push_dump();
    pulse_start();
    wait_word("t4_word4_seen", 4'd4);
    out_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t4_abort");
    sb.delete();
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("t4_no_partial_done", 64'(done_cnt), 64'd0);
    clear_counts();
    push_dump();
    pulse_start();
    wait_done("t4_done_seen");
    check("t4_done_count", 64'(done_cnt), 64'd1);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Writeback landing at the start of READ-of-5 is visible
    clear_counts();
    shadow[5] = 32'hDEADBEEF;
    push_dump();
    pulse_start();
    wait_word("t5a_word4_seen", 4'd4);
    rf_write(3'd5, 32'hDEADBEEF);
    wait_done("t5a_done_seen");
    check("t5a_sb_empty", 64'(sb.size()), 64'd0);
    rf_write(3'd5, 32'h51);

    // Writeback landing at the end of READ-of-5 is not visible
    clear_counts();
    push_dump();
    pulse_start();
    wait_word("t5b_word4_seen", 4'd4);
    tick();
    rf_write(3'd5, 32'hDEADBEEF);
    wait_done("t5b_done_seen");
    check("t5b_sb_empty", 64'(sb.size()), 64'd0);
    rf_write(3'd5, 32'h51);

    // One-hot register pattern; checksum word is 0xFF when enabled
    for (int i = 0; i < 8; i++) rf_write(3'(i), 32'h1 << i);
    clear_counts();
    push_dump();
    if (CSUM) check("t6_expected_csum", 64'(sb[8].data), 64'hFF);
    pulse_start();
    wait_done("t6_done_seen");
    check("t6_done_count", 64'(done_cnt), 64'd1);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
